seq_dot_product: RTL and testbench



---
 rtl/ann_pkg.sv | 14 +
 rtl/seq_dot_product_mac_unit.sv | 17 +
 rtl/seq_dot_product.sv | 98 +++++++++
 tb/tb_seq_dot_product.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared types for the sequential ANN arithmetic engines.
package ann_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef logic [DEFAULT_DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } dp_state_e;

endpackage

// File: rtl/seq_dot_product_mac_unit.sv
// Combinational multiply-accumulate: sum = acc + a*b, truncated to DATA_W bits.
module mac_unit #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W-1:0] product;

  // Only the low DATA_W bits of the product matter; sums wrap modulo 2^DATA_W.
  assign product = a * b;
  assign sum     = acc + product;

endmodule

// File: rtl/seq_dot_product.sv
// Dot-product responder: one multiply-accumulate per clock over VECTOR_LEN elements.
module seq_dot_product
  import ann_pkg::*;
#(
  parameter int VECTOR_LEN = 4,
  parameter int DATA_W     = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] vec1 [VECTOR_LEN],
  input  logic [DATA_W-1:0] vec2 [VECTOR_LEN],
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              busy
);

  localparam int IDX_W = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_LEN - 1);

  dp_state_e         state;
  dp_state_e         state_next;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] elem_a;
  logic [DATA_W-1:0] elem_b;
  logic [DATA_W-1:0] mac_sum;
  logic              last;

  // Explicit mux keeps the element select in range for any VECTOR_LEN, including 1.
  always_comb begin
    elem_a = '0;
    elem_b = '0;
    for (int i = 0; i < VECTOR_LEN; i++) begin
      if (idx == IDX_W'(i)) begin
        elem_a = vec1[i];
        elem_b = vec2[i];
      end
    end
  end

  assign last = (idx == LAST_IDX);

  mac_unit #(
    .DATA_W(DATA_W)
  ) u_mac (
    .acc(acc),
    .a  (elem_a),
    .b  (elem_b),
    .sum(mac_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN:     if (last) state_next = DONE;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    done = (state == DONE);
    busy = (state == RUN);
  end

  // start has priority so a request on the final-element cycle aborts the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      acc    <= '0;
      result <= '0;
    end else if (start) begin
      idx <= '0;
      acc <= '0;
    end else if (state == RUN) begin
      acc <= mac_sum;
      if (last) begin
        result <= mac_sum;
        idx    <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_dot_product.sv
// Scoreboard bench for seq_dot_product: directed vectors, queued expectations, done-edge monitor.
module tb_seq_dot_product;
  import ann_pkg::*;

  typedef word_t vec4_t [4];

  logic  clk = 1'b0;
  logic  rst_n;
  logic  start;
  word_t v1 [4];
  word_t v2 [4];
  word_t result;
  logic  done;
  logic  busy;

  logic  start1;
  word_t a1 [1];
  word_t b1 [1];
  word_t result1;
  logic  done1;
  logic  busy1;

  int total = 0;
  int bad   = 0;

  word_t exp_q[$];
  word_t exp1_q[$];
  logic  done_q  = 1'b0;
  logic  done1_q = 1'b0;

  always #5 clk = ~clk;

  seq_dot_product #(.VECTOR_LEN(4), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .vec1  (v1),
    .vec2  (v2),
    .result(result),
    .done  (done),
    .busy  (busy)
  );

  seq_dot_product #(.VECTOR_LEN(1), .DATA_W(32)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .vec1  (a1),
    .vec2  (b1),
    .result(result1),
    .done  (done1),
    .busy  (busy1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every rising done consumes one queued expectation.
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done actual=%h required=none", result);
      end else begin
        checkOutput("result", result, exp_q.pop_front());
      end
    end
    if (done1 && !done1_q) begin
      if (exp1_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done1 actual=%h required=none", result1);
      end else begin
        checkOutput("result1", result1, exp1_q.pop_front());
      end
    end
    done_q  = done;
    done1_q = done1;
  end

  task automatic waitDone(input int exp_lat, input string name);
    int lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic applyStimulus(input vec4_t a, input vec4_t b, input word_t expected,
                               input string name);
    @(negedge clk);
    v1    = a;
    v2    = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({name, "_busy"}, {31'b0, busy}, 32'd1);
    exp_q.push_back(expected);
    waitDone(4, name);
  endtask

  initial begin
    vec4_t basic_a, basic_b, wrap_a, wrap_b, sgn_a, sgn_b, ones;
    basic_a = '{32'd1, 32'd2, 32'd3, 32'd4};
    basic_b = '{32'd5, 32'd6, 32'd7, 32'd8};
    wrap_a  = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
    wrap_b  = '{32'd2, 32'd0, 32'd0, 32'd0};
    sgn_a   = '{-32'sd3, 32'd2, 32'd0, 32'd0};
    sgn_b   = '{32'd4, 32'd5, 32'd0, 32'd0};
    ones    = '{32'd1, 32'd1, 32'd1, 32'd1};

    rst_n  = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    v1     = '{default: '0};
    v2     = '{default: '0};
    a1     = '{default: '0};
    b1     = '{default: '0};

    repeat (2) @(negedge clk);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle_done", {31'b0, done}, 32'd0);
      checkOutput("idle_busy", {31'b0, busy}, 32'd0);
      checkOutput("idle_result", result, 32'd0);
    end

    applyStimulus(basic_a, basic_b, 32'd70, "basic");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("hold_done", {31'b0, done}, 32'd1);
      checkOutput("hold_result", result, 32'd70);
    end

    applyStimulus(wrap_a, wrap_b, 32'hFFFF_FFFE, "wrap");
    applyStimulus(sgn_a, sgn_b, 32'hFFFF_FFFE, "signed");

    // Abort after two consumed elements; only the restarted run may complete.
    @(negedge clk);
    v1    = basic_a;
    v2    = basic_b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    v1    = ones;
    v2    = ones;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back(32'd4);
    waitDone(4, "restart");

    // Start coincides with the final element: no result may appear.
    @(negedge clk);
    v1    = basic_a;
    v2    = basic_b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("final_abort_done", {31'b0, done}, 32'd0);
      checkOutput("final_abort_busy", {31'b0, busy}, 32'd1);
    end
    start = 1'b0;
    exp_q.push_back(32'd70);
    waitDone(4, "after_final_abort");

    applyStimulus(sgn_a, sgn_b, 32'hFFFF_FFFE, "pre_reset");

    // Asynchronous reset between edges during RUN.
    @(negedge clk);
    v1    = basic_a;
    v2    = basic_b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_done", {31'b0, done}, 32'd0);
    checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
    checkOutput("midreset_result", result, 32'd0);
    #1 rst_n = 1'b1;
    applyStimulus(basic_a, basic_b, 32'd70, "post_reset");

    // Single-element engine.
    @(negedge clk);
    a1[0]  = 32'd7;
    b1[0]  = 32'd6;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    exp1_q.push_back(32'd42);
    checkOutput("len1_busy", {31'b0, busy1}, 32'd1);
    @(negedge clk);
    checkOutput("len1_done", {31'b0, done1}, 32'd1);
    @(negedge clk);
    checkOutput("len1_hold", result1, 32'd42);

    repeat (2) @(negedge clk);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("queue1_empty", 32'(exp1_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
